// File: rtl/fx2_fifo_sequencer.sv
// Time-shares the FX2 slave-FIFO bus between the sample writer (FIFO4) and the
// command reader (FIFO2), and commits short packets with PKTEND on flush requests.
module fx2_fifo_sequencer #(
    parameter logic [1:0] WR_FIFOADR = 2'b10,
    parameter logic [1:0] RD_FIFOADR = 2'b00,
    parameter int         ADDR_SETUP = 2,
    parameter int         WR_BURST   = 512,
    parameter int         RD_BURST   = 64
) (
    input  logic       FIFO_clk,
    input  logic       reset,
    input  logic       fifo2_empty,
    input  logic       fifo4_full,
    input  logic [7:0] fd_in,
    output logic [7:0] fd_out,
    output logic       fd_oe,
    output logic       sloe,
    output logic       slrd,
    output logic       slwr,
    output logic       pktend,
    output logic [1:0] fifoadr,
    input  logic [7:0] samp_data,
    input  logic       samp_valid,
    output logic       samp_ready,
    output logic [7:0] cmd_data,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    input  logic       flush_req,
    output logic       flush_done
);

    localparam int MAX_BURST = (WR_BURST > RD_BURST) ? WR_BURST : RD_BURST;
    localparam int CNT_W     = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] WR_LIMIT   = CNT_W'(WR_BURST);
    localparam logic [CNT_W-1:0] RD_LIMIT   = CNT_W'(RD_BURST);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(ADDR_SETUP - 1);

    typedef enum logic [2:0] {IDLE, SETUP, WR, RD, PKT} state_t;
    typedef enum logic [1:0] {DIR_NONE, DIR_WR, DIR_RD} dir_t;

    state_t           r_state;
    state_t           r_target;
    dir_t             r_dir;
    logic [1:0]       r_fifoadr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_flushPending;
    logic             r_flushDone;

    state_t     w_nextState;
    state_t     w_nextTarget;
    logic [1:0] w_nextFifoadr;
    logic       w_flushAny;
    logic       w_leaving;
    logic       w_cntInc;
    logic       w_sampReady;
    logic       w_slwr;
    logic       w_slrd;
    logic       w_cmdValid;
    logic       w_pktend;
    logic       w_fdOe;
    logic       w_sloe;

    // A flush arriving this cycle is acted on immediately, not a cycle late.
    assign w_flushAny = r_flushPending | flush_req;

    always_comb begin
        w_nextState   = r_state;
        w_nextTarget  = r_target;
        w_nextFifoadr = r_fifoadr;
        w_leaving     = 1'b0;
        w_cntInc      = 1'b0;
        w_sampReady   = 1'b0;
        w_slwr        = 1'b0;
        w_slrd        = 1'b0;
        w_cmdValid    = 1'b0;
        w_pktend      = 1'b0;
        w_fdOe        = 1'b0;
        w_sloe        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_flushAny) begin
                    if (r_fifoadr == WR_FIFOADR && r_dir == DIR_WR) begin
                        w_nextState = PKT;
                    end else begin
                        w_nextState   = SETUP;
                        w_nextTarget  = PKT;
                        w_nextFifoadr = WR_FIFOADR;
                    end
                end else if (!fifo2_empty) begin
                    if (r_fifoadr == RD_FIFOADR && r_dir == DIR_RD) begin
                        w_nextState = RD;
                    end else begin
                        w_nextState   = SETUP;
                        w_nextTarget  = RD;
                        w_nextFifoadr = RD_FIFOADR;
                    end
                end else if (samp_valid) begin
                    if (r_fifoadr == WR_FIFOADR && r_dir == DIR_WR) begin
                        w_nextState = WR;
                    end else begin
                        w_nextState   = SETUP;
                        w_nextTarget  = WR;
                        w_nextFifoadr = WR_FIFOADR;
                    end
                end
            end
            SETUP: begin
                w_cntInc = 1'b1;
                if (r_cnt == SETUP_LAST) begin
                    w_nextState = r_target;
                end
            end
            WR: begin
                w_fdOe      = 1'b1;
                w_leaving   = w_flushAny
                            | ((r_cnt == WR_LIMIT) & !fifo2_empty)
                            | (!samp_valid & !fifo2_empty)
                            | (fifo4_full & !fifo2_empty);
                w_sampReady = !fifo4_full & !w_leaving;
                w_slwr      = samp_valid & w_sampReady;
                // Hold at the limit so a command arriving late still preempts.
                w_cntInc    = w_slwr & (r_cnt != WR_LIMIT);
                if (w_leaving) begin
                    w_nextState = w_flushAny ? PKT : IDLE;
                end
            end
            RD: begin
                w_sloe     = 1'b1;
                w_leaving  = fifo2_empty
                           | ((r_cnt == RD_LIMIT) & samp_valid)
                           | w_flushAny;
                w_cmdValid = !fifo2_empty & !w_leaving;
                w_slrd     = w_cmdValid & cmd_ready;
                w_cntInc   = w_slrd & (r_cnt != RD_LIMIT);
                if (w_leaving) begin
                    w_nextState = IDLE;
                end
            end
            PKT: begin
                if (!fifo4_full) begin
                    w_pktend    = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Counter restarts on every state change; direction tracks the last bus owner.
    always_ff @(posedge FIFO_clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_target       <= WR;
            r_dir          <= DIR_NONE;
            r_fifoadr      <= WR_FIFOADR;
            r_cnt          <= '0;
            r_flushPending <= 1'b0;
            r_flushDone    <= 1'b0;
        end else begin
            r_state        <= w_nextState;
            r_target       <= w_nextTarget;
            r_fifoadr      <= w_nextFifoadr;
            r_flushPending <= flush_req | (r_flushPending & !w_pktend);
            r_flushDone    <= w_pktend;
            if (w_nextState != r_state) begin
                r_cnt <= '0;
            end else if (w_cntInc) begin
                r_cnt <= r_cnt + 1'b1;
            end
            case (w_nextState)
                WR, PKT: r_dir <= DIR_WR;
                RD:      r_dir <= DIR_RD;
                default: ;
            endcase
        end
    end

    assign fd_out     = (r_state == WR) ? samp_data : 8'h00;
    assign fd_oe      = w_fdOe;
    assign sloe       = w_sloe;
    assign slrd       = w_slrd;
    assign slwr       = w_slwr;
    assign pktend     = w_pktend;
    assign fifoadr    = r_fifoadr;
    assign samp_ready = w_sampReady;
    assign cmd_data   = fd_in;
    assign cmd_valid  = w_cmdValid;
    assign flush_done = r_flushDone;

endmodule

// File: tb/tb_fx2_fifo_sequencer.sv
// Bench for fx2_fifo_sequencer: a cycle vector table, directed burst/reset
// sequences, and a constrained-random run with invariant and order checks.
module tb_fx2_fifo_sequencer;

    logic       FIFO_clk;
    logic       reset;
    logic       fifo2_empty;
    logic       fifo4_full;
    logic [7:0] fd_in;
    logic [7:0] fd_out;
    logic       fd_oe;
    logic       sloe;
    logic       slrd;
    logic       slwr;
    logic       pktend;
    logic [1:0] fifoadr;
    logic [7:0] samp_data;
    logic       samp_valid;
    logic       samp_ready;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       flush_req;
    logic       flush_done;

    int checkCount = 0;
    int passCount  = 0;

    fx2_fifo_sequencer dut (
        .FIFO_clk    (FIFO_clk),
        .reset       (reset),
        .fifo2_empty (fifo2_empty),
        .fifo4_full  (fifo4_full),
        .fd_in       (fd_in),
        .fd_out      (fd_out),
        .fd_oe       (fd_oe),
        .sloe        (sloe),
        .slrd        (slrd),
        .slwr        (slwr),
        .pktend      (pktend),
        .fifoadr     (fifoadr),
        .samp_data   (samp_data),
        .samp_valid  (samp_valid),
        .samp_ready  (samp_ready),
        .cmd_data    (cmd_data),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .flush_req   (flush_req),
        .flush_done  (flush_done)
    );

    initial FIFO_clk = 1'b0;
    always #5 FIFO_clk = ~FIFO_clk;

    typedef struct {
        logic       sv;
        logic [7:0] sd;
        logic       f2e;
        logic       f4f;
        logic       crdy;
        logic [7:0] fdin;
        logic       flr;
        logic [7:0] expCtl;
        logic [1:0] expAdr;
        logic [7:0] expFdOut;
    } vec_t;

    vec_t vecs[25];

    function automatic vec_t mk(logic sv, logic [7:0] sd, logic f2e, logic f4f, logic crdy,
                                logic [7:0] fdin, logic flr, logic [7:0] ctl, logic [1:0] adr,
                                logic [7:0] fdo);
        vec_t v;
        v.sv = sv; v.sd = sd; v.f2e = f2e; v.f4f = f4f; v.crdy = crdy;
        v.fdin = fdin; v.flr = flr; v.expCtl = ctl; v.expAdr = adr; v.expFdOut = fdo;
        return v;
    endfunction

    function automatic logic [7:0] ctlNow();
        return {slwr, slrd, fd_oe, sloe, pktend, flush_done, samp_ready, cmd_valid};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    task automatic applyStimulus(input vec_t v);
        samp_valid  = v.sv;
        samp_data   = v.sd;
        fifo2_empty = v.f2e;
        fifo4_full  = v.f4f;
        cmd_ready   = v.crdy;
        fd_in       = v.fdin;
        flush_req   = v.flr;
    endtask

    // Reset is checked while still asserted, then released just after an edge.
    task automatic applyReset();
        reset = 1'b1;
        samp_valid = 0; samp_data = 0; fifo2_empty = 1; fifo4_full = 0;
        cmd_ready = 0; fd_in = 0; flush_req = 0;
        repeat (2) @(posedge FIFO_clk);
        #1;
        checkOutput("reset_state", 32'({ctlNow(), fifoadr}), 32'({8'h00, 2'b10}));
        reset = 1'b0;
    endtask

    logic [7:0] wrNext;
    logic [7:0] rdNext;
    int wrCount, stallCycles, setupCycles, stallLeft, wrErr;
    bit stallStarted, gotRd, gotSloe;

    initial begin
        reset = 1'b1;

        // Vector table: write start, full stall, flush, merged repeat, read, flush from WR.
        vecs[0]  = mk(1, 8'h00, 1, 0, 1, 8'h00, 0, 8'b0000_0000, 2'b10, 8'h00);
        vecs[1]  = mk(1, 8'h00, 1, 0, 1, 8'h00, 0, 8'b0000_0000, 2'b10, 8'h00);
        vecs[2]  = mk(1, 8'h00, 1, 0, 1, 8'h00, 0, 8'b0000_0000, 2'b10, 8'h00);
        vecs[3]  = mk(1, 8'h00, 1, 0, 1, 8'h00, 0, 8'b1010_0010, 2'b10, 8'h00);
        vecs[4]  = mk(1, 8'h01, 1, 0, 1, 8'h00, 0, 8'b1010_0010, 2'b10, 8'h01);
        vecs[5]  = mk(1, 8'h02, 1, 1, 1, 8'h00, 0, 8'b0010_0000, 2'b10, 8'h02);
        vecs[6]  = mk(1, 8'h02, 1, 0, 1, 8'h00, 0, 8'b1010_0010, 2'b10, 8'h02);
        vecs[7]  = mk(0, 8'h03, 1, 0, 1, 8'h00, 0, 8'b0010_0010, 2'b10, 8'h03);
        vecs[8]  = mk(1, 8'h03, 1, 0, 1, 8'h00, 1, 8'b0010_0000, 2'b10, 8'h03);
        vecs[9]  = mk(1, 8'h04, 1, 1, 1, 8'h00, 1, 8'b0000_0000, 2'b10, 8'h00);
        vecs[10] = mk(1, 8'h04, 1, 0, 1, 8'h00, 0, 8'b0000_1000, 2'b10, 8'h00);
        vecs[11] = mk(1, 8'h04, 0, 0, 1, 8'hA5, 0, 8'b0000_0100, 2'b10, 8'h00);
        vecs[12] = mk(1, 8'h04, 0, 0, 1, 8'hA5, 0, 8'b0000_0000, 2'b00, 8'h00);
        vecs[13] = mk(1, 8'h04, 0, 0, 1, 8'hA5, 0, 8'b0000_0000, 2'b00, 8'h00);
        vecs[14] = mk(1, 8'h04, 0, 0, 1, 8'hA5, 0, 8'b0101_0001, 2'b00, 8'h00);
        vecs[15] = mk(1, 8'h04, 0, 0, 0, 8'h5A, 0, 8'b0001_0001, 2'b00, 8'h00);
        vecs[16] = mk(1, 8'h04, 0, 0, 1, 8'h5A, 0, 8'b0101_0001, 2'b00, 8'h00);
        vecs[17] = mk(1, 8'h04, 1, 0, 1, 8'h5A, 0, 8'b0001_0000, 2'b00, 8'h00);
        vecs[18] = mk(1, 8'h10, 1, 0, 1, 8'h00, 0, 8'b0000_0000, 2'b00, 8'h00);
        vecs[19] = mk(1, 8'h10, 1, 0, 1, 8'h00, 0, 8'b0000_0000, 2'b10, 8'h00);
        vecs[20] = mk(1, 8'h10, 1, 0, 1, 8'h00, 0, 8'b0000_0000, 2'b10, 8'h00);
        vecs[21] = mk(1, 8'h10, 1, 0, 1, 8'h00, 0, 8'b1010_0010, 2'b10, 8'h10);
        vecs[22] = mk(0, 8'h10, 1, 0, 1, 8'h00, 1, 8'b0010_0000, 2'b10, 8'h10);
        vecs[23] = mk(0, 8'h10, 1, 0, 1, 8'h00, 0, 8'b0000_1000, 2'b10, 8'h00);
        vecs[24] = mk(0, 8'h10, 1, 0, 1, 8'h00, 0, 8'b0000_0100, 2'b10, 8'h00);

        applyReset();
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            @(negedge FIFO_clk);
            checkOutput($sformatf("vec%0d", i), 32'({ctlNow(), fifoadr, fd_out}),
                        32'({vecs[i].expCtl, vecs[i].expAdr, vecs[i].expFdOut}));
            @(posedge FIFO_clk);
            #1;
        end

        // Long write burst with a 5-cycle full stall, then a command preempts at the burst limit.
        applyReset();
        samp_valid = 1; fifo2_empty = 1; fifo4_full = 0; cmd_ready = 1; fd_in = 8'hA5;
        wrNext = 0; samp_data = 0; wrCount = 0; stallCycles = 0; setupCycles = 0;
        stallLeft = 0; stallStarted = 0; wrErr = 0; gotRd = 0;
        for (int cyc = 0; cyc < 800 && !gotRd; cyc++) begin
            @(negedge FIFO_clk);
            if (sloe) begin
                gotRd = 1;
            end else begin
                if (slwr) begin
                    if (fd_out !== wrNext) wrErr++;
                    wrNext++;
                    wrCount++;
                end else if (fd_oe && !samp_ready && wrCount < 512) begin
                    stallCycles++;
                end
                if (!fd_oe && fifoadr == 2'b00) setupCycles++;
                @(posedge FIFO_clk);
                #1;
                samp_data = wrNext;
                if (wrCount == 5 && !stallStarted) begin
                    stallStarted = 1;
                    stallLeft = 5;
                end
                fifo4_full = (stallLeft > 0);
                if (stallLeft > 0) stallLeft--;
                if (wrCount >= 10) fifo2_empty = 0;
            end
        end
        checkOutput("rd_reached", 32'(gotRd), 32'd1);
        checkOutput("wr_burst_len", 32'(wrCount), 32'd512);
        checkOutput("wr_byte_order", 32'(wrErr), 32'd0);
        checkOutput("full_stall_cycles", 32'(stallCycles), 32'd5);
        checkOutput("setup_cycles", 32'(setupCycles), 32'd2);
        checkOutput("rd_fifoadr", 32'(fifoadr), 32'd0);
        checkOutput("rd_byte0", 32'({slrd, cmd_valid, cmd_data}), 32'({2'b11, 8'hA5}));
        @(posedge FIFO_clk); #1;
        fd_in = 8'h5A; cmd_ready = 0;
        @(negedge FIFO_clk);
        checkOutput("rd_backpressure", 32'({slrd, cmd_valid, cmd_data}), 32'({2'b01, 8'h5A}));
        @(posedge FIFO_clk); #1;
        cmd_ready = 1;
        @(negedge FIFO_clk);
        checkOutput("rd_byte1", 32'({slrd, cmd_valid, cmd_data}), 32'({2'b11, 8'h5A}));
        @(posedge FIFO_clk); #1;
        fifo2_empty = 1;
        @(negedge FIFO_clk);
        checkOutput("rd_exit_empty", 32'({slrd, cmd_valid, sloe}), 32'(3'b001));

        // Reset mid read burst drops every strobe immediately.
        applyReset();
        samp_valid = 0; fifo2_empty = 0; cmd_ready = 1; fd_in = 8'h33;
        gotSloe = 0;
        for (int cyc = 0; cyc < 10 && !gotSloe; cyc++) begin
            @(negedge FIFO_clk);
            if (sloe) gotSloe = 1;
            else begin @(posedge FIFO_clk); #1; end
        end
        checkOutput("rd_before_reset", 32'({sloe, slrd, fifoadr}), 32'({2'b11, 2'b00}));
        #1 reset = 1'b1;
        #1;
        checkOutput("rd_reset_drop", 32'({slrd, sloe, cmd_valid, fifoadr}), 32'({3'b000, 2'b10}));
        fifo2_empty = 1;
        @(posedge FIFO_clk); #1;
        reset = 1'b0;
        @(negedge FIFO_clk);
        checkOutput("post_reset_idle", 32'({ctlNow(), fifoadr}), 32'({8'h00, 2'b10}));

        runRandom();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    // Random flags/handshakes with invariant checks and byte-order scoreboards.
    task automatic runRandom();
        int invOe, invStrobeAdr, invSetupAge, invWr, invRd, invPkt, invFlush, wrTotal, rdTotal;
        int pktCount, doneCount, age;
        logic [1:0] prevAdr;
        bit outstanding, prevPkt;
        invOe = 0; invStrobeAdr = 0; invSetupAge = 0; invWr = 0; invRd = 0; invPkt = 0;
        invFlush = 0; wrTotal = 0; rdTotal = 0; pktCount = 0; doneCount = 0; age = 0;
        outstanding = 0; prevPkt = 0;
        applyReset();
        prevAdr = fifoadr;
        wrNext = 8'h00; rdNext = 8'h80;
        for (int cyc = 0; cyc < 3020; cyc++) begin
            if (cyc < 3000) begin
                samp_valid  = ($urandom_range(0, 3) != 0);
                fifo2_empty = ($urandom_range(0, 1) == 0);
                fifo4_full  = ($urandom_range(0, 7) == 0);
                cmd_ready   = ($urandom_range(0, 3) != 0);
                flush_req   = ($urandom_range(0, 63) == 0);
            end else begin
                samp_valid = 0; fifo2_empty = 1; fifo4_full = 0; flush_req = 0;
            end
            samp_data = wrNext;
            fd_in     = rdNext;
            @(negedge FIFO_clk);
            if (fifoadr != prevAdr) age = 0;
            else if (age < 1000) age++;
            if (fd_oe && sloe) invOe++;
            if ((slwr || slrd) && fifoadr != prevAdr) invStrobeAdr++;
            if ((slwr || slrd) && age < 2) invSetupAge++;
            if (slwr !== (samp_valid & samp_ready) || (slwr && (fifo4_full || !fd_oe || fifoadr != 2'b10)))
                invWr++;
            if (slrd !== (cmd_valid & cmd_ready) || (slrd && (fifo2_empty || !sloe || fifoadr != 2'b00)))
                invRd++;
            if (pktend && (slwr || slrd || fifo4_full || fifoadr != 2'b10)) invPkt++;
            if ((pktend && !outstanding) || flush_done !== prevPkt) invFlush++;
            if (slwr) begin
                if (fd_out !== wrNext) invWr++;
                wrNext++;
                wrTotal++;
            end
            if (slrd) begin
                if (cmd_data !== rdNext) invRd++;
                rdNext++;
                rdTotal++;
            end
            if (pktend) pktCount++;
            if (flush_done) doneCount++;
            outstanding = flush_req | (outstanding & !pktend);
            prevPkt = pktend;
            prevAdr = fifoadr;
            @(posedge FIFO_clk);
            #1;
        end
        checkOutput("rand_oe_exclusive", 32'(invOe), 32'd0);
        checkOutput("rand_adr_stable", 32'(invStrobeAdr), 32'd0);
        checkOutput("rand_setup_age", 32'(invSetupAge), 32'd0);
        checkOutput("rand_write_path", 32'(invWr), 32'd0);
        checkOutput("rand_read_path", 32'(invRd), 32'd0);
        checkOutput("rand_pktend", 32'(invPkt), 32'd0);
        checkOutput("rand_flush_seq", 32'(invFlush), 32'd0);
        checkOutput("rand_flush_drained", 32'(outstanding), 32'd0);
        checkOutput("rand_done_count", 32'(doneCount), 32'(pktCount));
        checkOutput("rand_traffic", 32'({wrTotal > 100, rdTotal > 100, pktCount > 5}), 32'(3'b111));
    endtask

endmodule
